// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit register CPU: sequencer state encoding,
// opcode constants and the instruction word layout.
package cpu_pkg;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned REG_W   = 2;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        SEQ_IDLE  = 2'b00,
        SEQ_FETCH = 2'b01,
        SEQ_ISSUE = 2'b10,
        SEQ_HALT  = 2'b11
    } seq_state_e;

    localparam logic [OPC_W-1:0] OP_NOP = 4'b0000;
    localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OPC_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OPC_W-1:0] OP_HLT = 4'b1111;

    // {opcode[7:4], dst[3:2], src[1:0]}
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] src;
    } instr_t;

    function automatic logic is_hlt(input instr_t i_instr);
        return i_instr.opcode == OP_HLT;
    endfunction

endpackage

// File: rtl/prog_mem.sv
// Program memory: DEPTH x 8 array, synchronous write, registered read.
// A write to the address being read is forwarded so it is seen immediately.
module prog_mem
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [INSTR_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_sequencer.sv
// Instruction sequencer: fetches words from prog_mem and issues them to the
// datapath over valid/ready. Optional breakpoint logic under SEQ_BREAKPOINT_EN.
module prog_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_we,
    input  logic [AW-1:0]      load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               run,
    input  logic               step,
    input  logic               halt_req,
    input  logic               pc_clr,
    output logic               issue_valid,
    output logic [INSTR_W-1:0] issue_instr,
    input  logic               issue_ready,
    output logic [AW-1:0]      pc,
    output logic [STATE_W-1:0] state,
    output logic               halted
`ifdef SEQ_BREAKPOINT_EN
    ,
    input  logic               bp_en,
    input  logic [AW-1:0]      bp_addr,
    output logic               bp_hit
`endif
);

    seq_state_e         r_state;
    seq_state_e         w_state_nxt;
    logic [AW-1:0]      r_pc;
    logic [AW-1:0]      w_pc_nxt;
    logic               r_run_mode;
    logic               w_run_mode_nxt;
    logic               r_halt_pend;
    logic               w_halt_pend_nxt;
    logic               r_issue_valid;
    logic               w_issue_valid_nxt;
    logic [INSTR_W-1:0] r_issue_instr;
    logic [INSTR_W-1:0] w_issue_instr_nxt;
    logic               r_halted;
    logic               w_halted_nxt;
    logic               w_mem_we;
    logic [INSTR_W-1:0] w_rd_data;
`ifdef SEQ_BREAKPOINT_EN
    logic               r_bp_hit;
    logic               w_bp_hit_nxt;
`endif

    // Program loads are only safe while nothing is being fetched or issued.
    assign w_mem_we = load_we && ((r_state == SEQ_IDLE) || (r_state == SEQ_HALT));

    // Read address follows the next pc so the word is ready during FETCH.
    prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_raddr (w_pc_nxt),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= SEQ_IDLE;
            r_pc          <= '0;
            r_run_mode    <= 1'b0;
            r_halt_pend   <= 1'b0;
            r_issue_valid <= 1'b0;
            r_issue_instr <= '0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_run_mode    <= w_run_mode_nxt;
            r_halt_pend   <= w_halt_pend_nxt;
            r_issue_valid <= w_issue_valid_nxt;
            r_issue_instr <= w_issue_instr_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

`ifdef SEQ_BREAKPOINT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bp_hit <= 1'b0;
        end else begin
            r_bp_hit <= w_bp_hit_nxt;
        end
    end

    assign bp_hit = r_bp_hit;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_run_mode_nxt    = r_run_mode;
        w_halt_pend_nxt   = r_halt_pend;
        w_issue_valid_nxt = 1'b0;
        w_issue_instr_nxt = r_issue_instr;
`ifdef SEQ_BREAKPOINT_EN
        w_bp_hit_nxt      = 1'b0;
`endif

        // run beats step; halt_req beats both. HALT ignores run/step entirely.
        if (r_state != SEQ_HALT) begin
            if (run) begin
                w_run_mode_nxt = 1'b1;
            end else if (step) begin
                w_run_mode_nxt = 1'b0;
            end
        end
        if (halt_req) begin
            w_run_mode_nxt = 1'b0;
        end

        case (r_state)
            SEQ_IDLE: begin
                if (pc_clr) begin
                    w_pc_nxt = '0;
                end else if (run || step) begin
                    w_state_nxt = SEQ_FETCH;
                end
            end
            SEQ_FETCH: begin
                if (halt_req) begin
                    w_state_nxt = SEQ_IDLE;
                end else if (is_hlt(instr_t'(w_rd_data))) begin
                    w_state_nxt    = SEQ_HALT;
                    w_run_mode_nxt = 1'b0;
                end else begin
                    w_state_nxt       = SEQ_ISSUE;
                    w_issue_valid_nxt = 1'b1;
                    w_issue_instr_nxt = w_rd_data;
                end
            end
            SEQ_ISSUE: begin
                w_issue_valid_nxt = 1'b1;
                if (halt_req) begin
                    w_halt_pend_nxt = 1'b1;
                end
                if (issue_ready) begin
                    w_issue_valid_nxt = 1'b0;
                    w_halt_pend_nxt   = 1'b0;
                    w_pc_nxt          = AW'(r_pc + AW'(1));
                    if (w_run_mode_nxt && !r_halt_pend) begin
                        w_state_nxt = SEQ_FETCH;
`ifdef SEQ_BREAKPOINT_EN
                        // Only continuation fetches are checked, so a fresh run steps past bp_addr.
                        if (bp_en && (w_pc_nxt == bp_addr)) begin
                            w_state_nxt    = SEQ_IDLE;
                            w_run_mode_nxt = 1'b0;
                            w_bp_hit_nxt   = 1'b1;
                        end
`endif
                    end else begin
                        w_state_nxt = SEQ_IDLE;
                    end
                end
            end
            SEQ_HALT: begin
                if (pc_clr) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = SEQ_IDLE;
                end
            end
            default: begin
                w_state_nxt = SEQ_IDLE;
            end
        endcase

        w_halted_nxt = (w_state_nxt == SEQ_HALT);
    end

    assign issue_valid = r_issue_valid;
    assign issue_instr = r_issue_instr;
    assign pc          = r_pc;
    assign state       = r_state;
    assign halted      = r_halted;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: a program-level model predicts the
// issued word stream, end state and pc; a monitor checks every handshake.
module tb_prog_sequencer;
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_we = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [7:0]    load_data = '0;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          halt_req = 1'b0;
    logic          pc_clr = 1'b0;
    logic          issue_valid;
    logic [7:0]    issue_instr;
    logic          issue_ready = 1'b1;
    logic [AW-1:0] pc;
    logic [1:0]    state;
    logic          halted;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_mem [DEPTH];
    int         model_pc = 0;
    logic       model_halted = 1'b0;
    int         ready_mode = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_instr = '0;

    prog_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .run         (run),
        .step        (step),
        .halt_req    (halt_req),
        .pc_clr      (pc_clr),
        .issue_valid (issue_valid),
        .issue_instr (issue_instr),
        .issue_ready (issue_ready),
        .pc          (pc),
        .state       (state),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ready: 0 = tied high, 1 = random, 2 = held low
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0)      issue_ready = 1'b1;
            else if (ready_mode == 2) issue_ready = 1'b0;
            else                      issue_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pop expected word on every handshake; check stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", int'(issue_valid), 1);
                chk("stall_instr", int'(issue_instr), int'(prev_instr));
            end
            if (issue_valid && issue_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got %02h expected none", issue_instr);
                end else begin
                    chk("issue_instr", int'(issue_instr), int'(exp_q.pop_front()));
                end
            end
            prev_stall = issue_valid && !issue_ready;
            prev_instr = issue_instr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int a, input logic [7:0] d);
        load_we = 1'b1; load_addr = AW'(a); load_data = d;
        tick();
        load_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic pulse_run();  run = 1'b1;      tick(); run = 1'b0;      endtask
    task automatic pulse_step(); step = 1'b1;     tick(); step = 1'b0;     endtask
    task automatic pulse_halt(); halt_req = 1'b1; tick(); halt_req = 1'b0; endtask
    task automatic pulse_clr();  pc_clr = 1'b1;   tick(); pc_clr = 1'b0; model_pc = 0; model_halted = 1'b0; endtask

    // Model: free-run from model_pc until an HLT word.
    task automatic model_run();
        while (model_mem[model_pc][7:4] != OP_HLT) begin
            exp_q.push_back(model_mem[model_pc]);
            model_pc = (model_pc + 1) % DEPTH;
        end
        model_halted = 1'b1;
    endtask

    task automatic model_step();
        if (model_mem[model_pc][7:4] == OP_HLT) begin
            model_halted = 1'b1;
        end else begin
            exp_q.push_back(model_mem[model_pc]);
            model_pc = (model_pc + 1) % DEPTH;
        end
    endtask

    task automatic wait_settled(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state == 2'b00 || state == 2'b11) break;
        end
        if (i == budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL settle_timeout: got state %0d expected IDLE or HALT", state);
        end
        tick();
    endtask

    task automatic wait_valid(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (issue_valid) break;
        end
        if (i == budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL valid_timeout: got valid 0 expected 1");
        end
        tick();
    endtask

    task automatic check_model(input string name);
        chk({name, "_state"}, int'(state), model_halted ? 3 : 0);
        chk({name, "_pc"}, int'(pc), model_pc);
        chk({name, "_halted"}, int'(halted), int'(model_halted));
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int exp_state [6];
        exp_state = '{1, 2, 1, 2, 1, 3};

        tick(); tick();
        rst = 1'b0;
        // Reset values
        chk("rst_state", int'(state), 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_valid", int'(issue_valid), 0);
        chk("rst_instr", int'(issue_instr), 0);
        chk("rst_halted", int'(halted), 0);

        // Directed run with cycle-exact timing
        do_load(0, 8'h17); do_load(1, 8'h2B); do_load(2, 8'hF0);
        exp_q.push_back(8'h17); exp_q.push_back(8'h2B);
        pulse_run();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("run_c%0d_state", c + 1), int'(state), exp_state[c]);
            chk($sformatf("run_c%0d_valid", c + 1), int'(issue_valid), (exp_state[c] == 2) ? 1 : 0);
        end
        tick();
        model_pc = 2; model_halted = 1'b1;
        check_model("run_hlt");

        // run/step ignored in HALT, then pc_clr
        pulse_run(); pulse_step(); tick(); tick();
        check_model("halt_ignore");
        pulse_clr();
        check_model("clr");

        // Three steps; the third word is loaded in the same cycle as its step
        do_load(0, 8'h10); do_load(1, 8'h11);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                load_we = 1'b1; load_addr = AW'(2); load_data = 8'h12; model_mem[2] = 8'h12;
            end
            model_step();
            pulse_step();
            load_we = 1'b0;
            wait_settled(40);
            check_model($sformatf("step%0d", k));
        end

        // Stall with ready low; an attempted load during ISSUE must be ignored
        pulse_clr();
        do_load(0, 8'h21); do_load(1, 8'h35); do_load(2, 8'hF0);
        ready_mode = 2;
        model_run();
        pulse_run();
        wait_valid(40);
        load_we = 1'b1; load_addr = AW'(1); load_data = 8'h99;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_hold_instr", int'(issue_instr), 8'h21);
            chk("stall_hold_pc", int'(pc), 0);
            load_we = 1'b0;
        end
        tick();
        ready_mode = 0;
        wait_settled(60);
        check_model("stall_run");

        // halt_req during a stalled ISSUE completes the handshake then idles
        pulse_clr();
        ready_mode = 2;
        exp_q.push_back(model_mem[0]);
        pulse_run();
        wait_valid(40);
        pulse_halt();
        tick(); tick();
        ready_mode = 0;
        wait_settled(40);
        model_pc = 1;
        check_model("halt_pend");

        // pc wraps DEPTH-1 -> 0
        pulse_clr();
        for (int a = 0; a < DEPTH; a++) do_load(a, {4'h1, 4'($urandom_range(0, 15))});
        for (int k = 0; k < DEPTH - 1; k++) begin
            model_step();
            pulse_step();
            wait_settled(40);
        end
        check_model("pre_wrap");
        do_load(2, 8'hF3);
        model_run();
        pulse_run();
        wait_settled(80);
        check_model("wrap");

        // Randomised programs and control sequences
        for (int r = 0; r < 40; r++) begin
            pulse_clr();
            ready_mode = int'($urandom_range(0, 1));
            for (int a = 0; a < DEPTH; a++) begin
                logic [3:0] op;
                op = ($urandom_range(0, 5) == 0) ? OP_HLT : 4'($urandom_range(0, 14));
                do_load(a, {op, 4'($urandom_range(0, 15))});
            end
            do_load(int'($urandom_range(1, DEPTH - 1)), {OP_HLT, 4'h0});
            for (int k = 0; k < 4; k++) begin
                int act;
                act = int'($urandom_range(0, 3));
                if (act == 1) begin
                    if (!model_halted) model_step();
                    pulse_step();
                end else begin
                    if (!model_halted) model_run();
                    if (act == 3) begin run = 1'b1; step = 1'b1; tick(); run = 1'b0; step = 1'b0; end
                    else pulse_run();
                end
                if (!model_halted || state != 2'b11) wait_settled(400);
                tick(); tick();
                check_model($sformatf("rnd%0d_%0d", r, k));
            end
        end

        // Reset mid-issue abandons the instruction
        pulse_clr();
        ready_mode = 2;
        do_load(0, 8'h05);
        pulse_run();
        wait_valid(40);
        rst = 1'b1;
        tick();
        exp_q.delete();
        rst = 1'b0;
        ready_mode = 0;
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_valid", int'(issue_valid), 0);
        chk("mid_rst_instr", int'(issue_instr), 0);
        chk("mid_rst_pc", int'(pc), 0);
        tick(); tick();
        chk("mid_rst_quiet", int'(issue_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
